// File: rtl/operand_read_unit_pkg.sv
// Package riscv_pipe_pkg: widths, register-file geometry and the ID/EX entry
// layout shared by the operand read unit, its scoreboard and its interface.
//   XLEN          operand width
//   REG_AW        register address width (NREGS registers, x0 hardwired 0)
//   PAYLOAD_W     opaque pass-through field width
//   MAX_INFLIGHT  outstanding writes tolerated per destination register
//   CNT_W         width of one scoreboard counter
package riscv_pipe_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int NREGS        = 1 << REG_AW;
  localparam int PAYLOAD_W    = 32;
  localparam int MAX_INFLIGHT = 3;
  localparam int CNT_W        = 2;

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [XLEN-1:0]      xdata_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  localparam reg_addr_t ZERO_REG = '0;

  // One held ID/EX entry as presented to execute.
  typedef struct packed {
    xdata_t    rs1_data;
    xdata_t    rs2_data;
    reg_addr_t rd;
    logic      rd_wen;
    payload_t  payload;
  } idex_t;

endpackage

// File: rtl/operand_read_unit_if.sv
// Decode-to-execute channel of the operand read unit.
//   in_*  : decoded instruction offered by decode (valid/ready handshake)
//   out_* : ID/EX entry offered to execute (valid/ready handshake)
// Modports:
//   master : the decode/execute side (drives in_* request fields and out_ready)
//   slave  : the operand read unit (drives in_ready and the out_* entry)
interface operand_read_unit_if;
  import riscv_pipe_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  reg_addr_t in_rd;
  logic      in_rd_wen;
  payload_t  in_payload;

  logic      out_valid;
  logic      out_ready;
  xdata_t    out_rs1_data;
  xdata_t    out_rs2_data;
  reg_addr_t out_rd;
  logic      out_rd_wen;
  payload_t  out_payload;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_payload, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wen,
           out_payload
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_payload, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wen,
           out_payload
  );

endinterface

// File: rtl/operand_read_unit_reg_scoreboard.sv
// reg_scoreboard: one pending-write counter per architectural register.
//   clk, reset            clock / asynchronous active-low reset
//   inc_addr, inc_en      count one more outstanding write (issue to execute)
//   dec_addr, dec_en      retire one outstanding write (writeback)
//   rd_addr_a/b/c         combinational counter read addresses
//   pend_a/b/c            counter values at those addresses
//   busy                  any counter nonzero
// x0 is never counted. A retire on a counter already at zero is dropped, so
// stale writebacks cannot underflow. Increment and retire of the same register
// in one cycle cancel.
module reg_scoreboard
  import riscv_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t inc_addr,
  input  logic      inc_en,
  input  reg_addr_t dec_addr,
  input  logic      dec_en,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  input  reg_addr_t rd_addr_c,
  output cnt_t      pend_a,
  output cnt_t      pend_b,
  output cnt_t      pend_c,
  output logic      busy
);

  cnt_t             cnt [NREGS];
  logic [NREGS-1:0] inc_hit;
  logic [NREGS-1:0] dec_hit;
  logic [NREGS-1:0] nonzero;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc_en && (inc_addr != ZERO_REG)) inc_hit[inc_addr] = 1'b1;
    // Retire only against an existing count.
    if (dec_en && (dec_addr != ZERO_REG) && (cnt[dec_addr] != '0))
      dec_hit[dec_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (inc_hit[i] && !dec_hit[i])
          cnt[i] <= cnt[i] + cnt_t'(1);
        else if (dec_hit[i] && !inc_hit[i])
          cnt[i] <= cnt[i] - cnt_t'(1);
      end
    end
  end

  always_comb begin
    nonzero = '0;
    for (int i = 0; i < NREGS; i++) nonzero[i] = (cnt[i] != '0);
  end

  assign busy   = |nonzero;
  assign pend_a = cnt[rd_addr_a];
  assign pend_b = cnt[rd_addr_b];
  assign pend_c = cnt[rd_addr_c];

endmodule

// File: rtl/operand_read_unit.sv
// operand_read_unit: decode-side reader of the integer register file.
//   clk, reset                    clock / asynchronous active-low reset
//   bus (slave)                   decoded-instruction input and ID/EX output
//   read_address_port_a/b         register-file read addresses (= in_rs1/in_rs2)
//   read_data_port_a/b            register-file read data (combinational)
//   wb_address/wb_data/wb_enable  writeback snoop, same net as the regfile write
//   flush                         squash the held ID/EX entry
//   sb_busy                       any outstanding write tracked
// Operands come from the register file, bypassed by a same-cycle writeback.
// An instruction is held off while any source has an outstanding producer
// (issued and not written back, or still sitting in the ID/EX slot) or while
// its destination already has MAX_INFLIGHT writes in flight.
module operand_read_unit
  import riscv_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  operand_read_unit_if.slave   bus,
  output reg_addr_t            read_address_port_a,
  output reg_addr_t            read_address_port_b,
  input  xdata_t               read_data_port_a,
  input  xdata_t               read_data_port_b,
  input  reg_addr_t            wb_address,
  input  xdata_t               wb_data,
  input  logic                 wb_enable,
  input  logic                 flush,
  output logic                 sb_busy
);

  // Bypass mux: x0 reads zero, a writeback landing this edge wins over the
  // stale register-file value.
  function automatic xdata_t select_operand(input reg_addr_t rs,
                                            input logic      byp_hit,
                                            input xdata_t    byp_data,
                                            input xdata_t    rf_data);
    if (rs == ZERO_REG) return '0;
    if (byp_hit)        return byp_data;
    return rf_data;
  endfunction

  // A single pending write is resolved if its writeback is arriving now;
  // two or more cannot all be resolved in one cycle.
  function automatic logic raw_hazard(input reg_addr_t rs,
                                      input cnt_t      pend,
                                      input logic      byp_hit,
                                      input logic      held_hit);
    if (rs == ZERO_REG) return 1'b0;
    return (pend > cnt_t'(1)) || ((pend == cnt_t'(1)) && !byp_hit) || held_hit;
  endfunction

  logic      vld_p1;
  idex_t     entry_p1;
  idex_t     entry_p0;
  logic      vld_nxt;

  cnt_t      pend_rs1;
  cnt_t      pend_rs2;
  cnt_t      pend_rd;

  logic      byp_hit_a;
  logic      byp_hit_b;
  logic      held_hit_a;
  logic      held_hit_b;
  logic      held_hit_rd;
  logic      haz_a;
  logic      haz_b;
  logic      cap_block;
  logic      slot_free;
  logic      ready;
  logic      accept;
  logic      handoff;

  assign read_address_port_a = bus.in_rs1;
  assign read_address_port_b = bus.in_rs2;

  assign byp_hit_a = wb_enable && (wb_address == bus.in_rs1);
  assign byp_hit_b = wb_enable && (wb_address == bus.in_rs2);

  // The held entry has not yet reached the scoreboard, so it is checked here.
  assign held_hit_a  = vld_p1 && entry_p1.rd_wen && (entry_p1.rd == bus.in_rs1);
  assign held_hit_b  = vld_p1 && entry_p1.rd_wen && (entry_p1.rd == bus.in_rs2);
  assign held_hit_rd = vld_p1 && entry_p1.rd_wen && (entry_p1.rd == bus.in_rd);

  assign haz_a = raw_hazard(bus.in_rs1, pend_rs1, byp_hit_a, held_hit_a);
  assign haz_b = raw_hazard(bus.in_rs2, pend_rs2, byp_hit_b, held_hit_b);

  // The held entry counts against capacity so the counter cannot overflow
  // when it is handed off.
  assign cap_block = bus.in_rd_wen && (bus.in_rd != ZERO_REG) &&
                     ((int'(pend_rd) + int'(held_hit_rd)) >= MAX_INFLIGHT);

  assign slot_free = !vld_p1 || bus.out_ready;
  assign ready     = !haz_a && !haz_b && !cap_block && slot_free && !flush;
  assign accept    = bus.in_valid && ready;
  assign handoff   = vld_p1 && bus.out_ready && !flush;

  always_comb begin
    entry_p0.rs1_data = select_operand(bus.in_rs1, byp_hit_a, wb_data, read_data_port_a);
    entry_p0.rs2_data = select_operand(bus.in_rs2, byp_hit_b, wb_data, read_data_port_b);
    entry_p0.rd       = bus.in_rd;
    entry_p0.rd_wen   = bus.in_rd_wen;
    entry_p0.payload  = bus.in_payload;
  end

  always_comb begin
    vld_nxt = vld_p1;
    if (flush)        vld_nxt = 1'b0;
    else if (accept)  vld_nxt = 1'b1;
    else if (handoff) vld_nxt = 1'b0;
  end

  reg_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .inc_addr  (entry_p1.rd),
    .inc_en    (handoff && entry_p1.rd_wen),
    .dec_addr  (wb_address),
    .dec_en    (wb_enable),
    .rd_addr_a (bus.in_rs1),
    .rd_addr_b (bus.in_rs2),
    .rd_addr_c (bus.in_rd),
    .pend_a    (pend_rs1),
    .pend_b    (pend_rs2),
    .pend_c    (pend_rd),
    .busy      (sb_busy)
  );

  // ---- stage p0 -> p1: ID/EX output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      entry_p1 <= '0;
    end else begin
      vld_p1 <= vld_nxt;
      if (accept) entry_p1 <= entry_p0;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = vld_p1;
  assign bus.out_rs1_data = entry_p1.rs1_data;
  assign bus.out_rs2_data = entry_p1.rs2_data;
  assign bus.out_rd       = entry_p1.rd;
  assign bus.out_rd_wen   = entry_p1.rd_wen;
  assign bus.out_payload  = entry_p1.payload;

endmodule
